// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_mode_e;

    // One buffered instruction: word plus the PC it was fetched from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is exposed combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int             DEPTH     = 2,
    parameter int             WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int            CW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             full;

    assign do_pop  = pop_i & (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // The issue rule reserves a slot for every response, so a push can never land on a full buffer.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests, buffers
// in-order responses and hands {inst, inst_pc} to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (halt on misaligned redirect
// and expose the sticky fetch_misaligned flag).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int           CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    fetch_mode_e   mode_q;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          req_fire;
    logic          keep_resp;
    logic          pop;
    logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          misaligned_q;
    assign target_pc        = redirect_pc;
    assign fetch_misaligned = misaligned_q;
`else
    // Without the trap, the low bits are simply ignored.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target_pc            = {redirect_pc[31:2], 2'b00};
`endif

    // Dropped responses stay counted in outstanding, so this bound also covers them.
    assign imem_req_valid = !rst && (mode_q == RUN) && !redirect_valid &&
                            (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_LIM);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign keep_resp      = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign push_entry     = '{inst: imem_resp_data, pc: resp_pc_q};

    assign inst_valid     = (fifo_count != '0);
    assign inst           = head.inst;
    assign inst_pc        = head.pc;

    // Next-state for PC tracking and the in-flight / discard counters.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        if (req_fire) begin
            pc_d = pc_q + PC_STEP;
        end
        if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (keep_resp) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        if (redirect_valid) begin
            // Everything still in flight belongs to the old path; a response
            // arriving right now is already accounted for by not counting it.
            pc_d       = target_pc;
            resp_pc_d  = target_pc;
            drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Fetch mode FSM: a misaligned redirect parks fetch in HALT until an aligned one arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                mode_q       <= HALT;
                misaligned_q <= 1'b1;
            end else begin
                mode_q       <= RUN;
                misaligned_q <= 1'b0;
            end
`else
            mode_q <= RUN;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .WIDTH     ($bits(fetch_entry_t)),
        .RESET_VAL ({32'h0000_0000, RESET_PC})
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (keep_resp),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency and a
// scoreboard of expected {inst, pc} derived from accepted requests.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] KEY        = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int mem_lat = 1;
    bit rnd     = 1'b0;

    // Reference state: next expected fetch address, expected decode stream,
    // and the memory's pending responses.
    logic [31:0] mpc = RESET_PC;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          due_q[$];
    int          last_due = 0;

    // Snapshot of the most recent cycle, taken mid-cycle.
    logic        obs_req_valid, obs_inst_valid, obs_fire;
    logic [31:0] obs_addr, obs_inst, obs_inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        obs_mis;
`endif

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
        return p;
`else
        return p & 32'hFFFF_FFFC;
`endif
    endfunction

    // One clock: observe at negedge, update model, then drive next-cycle inputs.
    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        obs_req_valid  = imem_req_valid;
        obs_addr       = imem_req_addr;
        obs_inst_valid = inst_valid;
        obs_inst       = inst;
        obs_inst_pc    = inst_pc;
        obs_fire       = !rst && imem_req_valid && imem_req_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
        obs_mis        = fetch_misaligned;
`endif
        if (rst) begin
            exp_q.delete(); mem_q.delete(); due_q.delete();
            last_due = 0;
            mpc = RESET_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            mpc = tgt(redirect_pc);
        end else if (inst_valid && inst_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got pc=%h inst=%h, none expected", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e || inst !== (e ^ KEY))
                    $display("FAIL pop_order: got pc=%h inst=%h, need pc=%h inst=%h",
                             inst_pc, inst, e, e ^ KEY);
                else n_pass++;
            end
        end
        if (obs_fire) begin
            n_total++;
            if (imem_req_addr !== mpc)
                $display("FAIL req_addr: got %h, need %h", imem_req_addr, mpc);
            else n_pass++;
            exp_q.push_back(imem_req_addr);
            mem_q.push_back(imem_req_addr);
            last_due = (last_due + 1 > cyc + mem_lat) ? last_due + 1 : cyc + mem_lat;
            due_q.push_back(last_due);
            mpc = imem_req_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q.pop_front() ^ KEY;
            void'(due_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        if (rnd) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic do_reset(input int lat);
        mem_lat = lat;
        rst = 1'b1; redirect_valid = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        n_total++;
        if (obs_req_valid !== 1'b0 || obs_addr !== RESET_PC)
            $display("FAIL reset_req: valid=%b addr=%h, need 0 %h", obs_req_valid, obs_addr, RESET_PC);
        else n_pass++;
        n_total++;
        if (obs_inst_valid !== 1'b0 || obs_inst !== 32'h0 || obs_inst_pc !== RESET_PC)
            $display("FAIL reset_inst: valid=%b inst=%h pc=%h, need 0 0 %h",
                     obs_inst_valid, obs_inst, obs_inst_pc, RESET_PC);
        else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_total++;
        if (obs_mis !== 1'b0) $display("FAIL reset_mis: got %b, need 0", obs_mis);
        else n_pass++;
`endif
    endtask

    task automatic test_stream();
        int first = -1;
        do_reset(1);
        inst_ready = 1'b1; imem_req_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k == 0) begin
                n_total++;
                if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC)
                    $display("FAIL first_req: valid=%b addr=%h, need 1 %h", obs_req_valid, obs_addr, RESET_PC);
                else n_pass++;
            end
            if (first < 0 && obs_inst_valid === 1'b1) first = k;
        end
        n_total++;
        if (first != 2) $display("FAIL first_inst_valid: cycle %0d, need 2", first);
        else n_pass++;
    endtask

    task automatic test_stall();
        int fires = 0;
        do_reset(1);
        inst_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (obs_fire) fires++;
        end
        n_total++;
        if (fires != FIFO_DEPTH) $display("FAIL stall_reqs: got %0d, need %0d", fires, FIFO_DEPTH);
        else n_pass++;
        n_total++;
        if (obs_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b, need 0", obs_req_valid);
        else n_pass++;
        inst_ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
    endtask

    task automatic test_redirect_inflight();
        int k;
        do_reset(3);
        inst_ready = 1'b1;
        cycle(); cycle();
        n_total++;
        if (mem_q.size() != 2) $display("FAIL inflight_count: got %0d, need 2", mem_q.size());
        else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        k = 0;
        do begin
            cycle(); k++;
        end while (obs_inst_valid !== 1'b1 && k < 20);
        n_total++;
        if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h100 || obs_inst !== (32'h100 ^ KEY))
            $display("FAIL redirect_inflight: valid=%b pc=%h inst=%h, need 1 %h %h",
                     obs_inst_valid, obs_inst_pc, obs_inst, 32'h100, 32'h100 ^ KEY);
        else n_pass++;
    endtask

    task automatic test_redirect_collide();
        bit hit = 1'b0;
        do_reset(1);
        inst_ready = 1'b1; imem_req_ready = 1'b1;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (imem_resp_valid && inst_valid) hit = 1'b1;
            else cycle();
        end
        n_total++;
        if (!hit) $display("FAIL collide_setup: no resp+pop cycle found, need one");
        else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_total++;
        if (obs_inst_valid !== 1'b0 || obs_req_valid !== 1'b1 || obs_addr !== 32'h40)
            $display("FAIL collide_n1: inst_valid=%b req=%b addr=%h, need 0 1 %h",
                     obs_inst_valid, obs_req_valid, obs_addr, 32'h40);
        else n_pass++;
        cycle();
        n_total++;
        if (obs_inst_valid !== 1'b0) $display("FAIL collide_n2: inst_valid=%b, need 0", obs_inst_valid);
        else n_pass++;
        cycle();
        n_total++;
        if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h40)
            $display("FAIL collide_n3: inst_valid=%b pc=%h, need 1 %h", obs_inst_valid, obs_inst_pc, 32'h40);
        else n_pass++;
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset(1);
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_total++;
            if (obs_mis !== 1'b1 || obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b0)
                $display("FAIL halt_state: mis=%b req=%b inst_valid=%b, need 1 0 0",
                         obs_mis, obs_req_valid, obs_inst_valid);
            else n_pass++;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_total++;
        if (obs_mis !== 1'b0 || obs_req_valid !== 1'b1 || obs_addr !== 32'h200)
            $display("FAIL halt_exit: mis=%b req=%b addr=%h, need 0 1 %h",
                     obs_mis, obs_req_valid, obs_addr, 32'h200);
        else n_pass++;
        for (int k = 0; k < 6; k++) cycle();
    endtask
`else
    task automatic test_align_force();
        do_reset(1);
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_total++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h100)
            $display("FAIL align_force: req=%b addr=%h, need 1 %h", obs_req_valid, obs_addr, 32'h100);
        else n_pass++;
        for (int k = 0; k < 6; k++) cycle();
    endtask
`endif

    task automatic test_random();
        do_reset($urandom_range(1, 4));
        rnd = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst = 1'b1;
                cycle();
                n_total++;
                if (obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b0)
                    $display("FAIL mid_reset: req=%b inst_valid=%b, need 0 0", obs_req_valid, obs_inst_valid);
                else n_pass++;
                rst = 1'b0;
                mem_lat = $urandom_range(1, 4);
            end
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            cycle();
        end
        redirect_valid = 1'b0;
        rnd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_align_force();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
